// File: rtl/mdio_pkg.sv
// mdio_pkg: Clause 22 frame constants, field widths and responder state encoding
package mdio_pkg;
    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;
    localparam int TA_W    = 2;
    localparam logic [3:0] S_PRE     = 4'd0;
    localparam logic [3:0] S_ST1     = 4'd1;
    localparam logic [3:0] S_OP      = 4'd2;
    localparam logic [3:0] S_PHYAD   = 4'd3;
    localparam logic [3:0] S_REGAD   = 4'd4;
    localparam logic [3:0] S_TA      = 4'd5;
    localparam logic [3:0] S_RD_DATA = 4'd6;
    localparam logic [3:0] S_WR_DATA = 4'd7;
    localparam logic [3:0] S_SKIP    = 4'd8;
endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: 2-FF synchronizers for mdc/mdio plus mdc rise (sample) and fall (drive) strobes
module mdio_sync_edge (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic mdc,
    input  logic mdio,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_sync
);
    logic [2:0] mdc_q;
    logic [1:0] mdio_q;
    // Two synchronizer stages, third mdc stage gives the previous value for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mdc_q  <= '0;
            mdio_q <= '0;
        end else begin
            mdc_q  <= {mdc_q[1:0], mdc};
            mdio_q <= {mdio_q[0], mdio};
        end
    end
    assign mdc_rise  = mdc_q[1] & ~mdc_q[2];
    assign mdc_fall  = ~mdc_q[1] & mdc_q[2];
    assign mdio_sync = mdio_q[1];
endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 PHY-side MDIO responder; define MDIO_PREAMBLE_SUPPRESS_EN to accept suppressed preambles after a good frame
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR     = 5'd0,
    parameter int         PREAMBLE_MIN = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        mdc,
    inout  wire         mdio,
    output logic [4:0]  reg_addr,
    output logic        reg_wr_en,
    output logic [15:0] reg_wr_data,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rd_data,
    output logic        busy,
    output logic        frame_err
);
    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

    logic               mdc_rise, mdc_fall, mdi;
    logic [3:0]         state;
    logic [4:0]         cnt;
    logic [5:0]         pre_cnt;
    logic               op_hi, op_rd, rd_lat, wr_pend, sup, pre_ok;
    logic               mdio_oe, mdio_do;
    logic [PHYAD_W-1:0] phyad;
    logic [REGAD_W-1:0] regad, regad_nx;
    logic [DATA_W-1:0]  shift, shift_nx;

    mdio_sync_edge u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .mdc       (mdc),
        .mdio      (mdio),
        .mdc_rise  (mdc_rise),
        .mdc_fall  (mdc_fall),
        .mdio_sync (mdi)
    );

    assign mdio     = mdio_oe ? mdio_do : 1'bz;
    assign regad_nx = {regad[REGAD_W-2:0], mdi};
    assign shift_nx = {shift[DATA_W-2:0], mdi};
    assign pre_ok   = pre_cnt >= (sup ? 6'd1 : PRE_MIN);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic frame_ok;
    assign frame_ok = (state == S_RD_DATA && mdc_fall && cnt == 5'(DATA_W)) ||
                      (state == S_WR_DATA && mdc_rise && cnt == 5'(DATA_W - 1));
    // Arm preamble suppression once a frame completes; a malformed frame disarms it
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            sup <= 1'b0;
        else if (frame_err)
            sup <= 1'b0;
        else if (frame_ok)
            sup <= 1'b1;
    end
`else
    assign sup = 1'b0;
`endif

    // Frame decoder: fields shift in on mdc rise, read data shifts out on mdc fall
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_PRE;
            cnt         <= '0;
            pre_cnt     <= '0;
            op_hi       <= 1'b0;
            op_rd       <= 1'b0;
            rd_lat      <= 1'b0;
            wr_pend     <= 1'b0;
            phyad       <= '0;
            regad       <= '0;
            shift       <= '0;
            mdio_oe     <= 1'b0;
            mdio_do     <= 1'b0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            reg_rd_en <= 1'b0;
            reg_wr_en <= wr_pend;
            wr_pend   <= 1'b0;
            frame_err <= 1'b0;
            rd_lat    <= reg_rd_en;
            if (rd_lat)
                shift <= reg_rd_data;
            case (state)
                S_PRE: if (mdc_rise) begin
                    if (mdi)
                        pre_cnt <= (pre_cnt >= PRE_MIN) ? pre_cnt : pre_cnt + 6'd1;
                    else if (pre_ok) begin
                        state   <= S_ST1;
                        busy    <= 1'b1;
                        pre_cnt <= '0;
                    end else
                        pre_cnt <= '0;
                end
                S_ST1: if (mdc_rise) begin
                    cnt <= '0;
                    if (mdi == MDIO_ST[0])
                        state <= S_OP;
                    else begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_PRE;
                    end
                end
                S_OP: if (mdc_rise) begin
                    cnt   <= cnt + 5'd1;
                    op_hi <= mdi;
                    if (cnt == 5'd1) begin
                        cnt <= '0;
                        if ({op_hi, mdi} == MDIO_OP_WR || {op_hi, mdi} == MDIO_OP_RD) begin
                            op_rd <= ({op_hi, mdi} == MDIO_OP_RD);
                            state <= S_PHYAD;
                        end else begin
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_PRE;
                        end
                    end
                end
                S_PHYAD: if (mdc_rise) begin
                    phyad <= {phyad[PHYAD_W-2:0], mdi};
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'(PHYAD_W - 1)) begin
                        cnt   <= '0;
                        state <= S_REGAD;
                    end
                end
                S_REGAD: if (mdc_rise) begin
                    regad <= regad_nx;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'(REGAD_W - 1)) begin
                        cnt <= '0;
                        if (phyad != PHY_ADDR)
                            state <= S_SKIP;
                        else begin
                            state <= S_TA;
                            if (op_rd) begin
                                reg_addr  <= regad_nx;
                                reg_rd_en <= 1'b1;
                            end
                        end
                    end
                end
                S_TA: if (op_rd ? mdc_fall : mdc_rise) begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(TA_W - 1)) begin
                        cnt     <= '0;
                        state   <= op_rd ? S_RD_DATA : S_WR_DATA;
                        mdio_oe <= op_rd;
                        mdio_do <= 1'b0;
                    end
                end
                S_RD_DATA: if (mdc_fall) begin
                    if (cnt == 5'(DATA_W)) begin
                        mdio_oe <= 1'b0;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        state   <= S_PRE;
                    end else begin
                        mdio_do <= shift[DATA_W-1];
                        shift   <= shift << 1;
                        cnt     <= cnt + 5'd1;
                    end
                end
                S_WR_DATA: if (mdc_rise) begin
                    shift <= shift_nx;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'(DATA_W - 1)) begin
                        reg_wr_data <= shift_nx;
                        reg_addr    <= regad;
                        wr_pend     <= 1'b1;
                        busy        <= 1'b0;
                        cnt         <= '0;
                        state       <= S_PRE;
                    end
                end
                S_SKIP: if (mdc_rise) begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(TA_W + DATA_W - 1)) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= S_PRE;
                    end
                end
                default: state <= S_PRE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed STA-side frames against mdio_responder (PHY_ADDR 0, PREAMBLE_MIN 32)
module tb_mdio_responder;
    import mdio_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n, mdc, sta_oe, sta_do;
    logic [15:0] reg_rd_data;
    logic [4:0]  reg_addr;
    logic        reg_wr_en, reg_rd_en, busy, frame_err;
    logic [15:0] reg_wr_data;
    wire         mdio;

    int tests = 0, fails = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cnt = 0;
    logic [4:0]  wr_addr_q = '0, rd_addr_q = '0;
    logic [15:0] wr_data_q = '0;

    assign mdio = sta_oe ? sta_do : 1'bz;

    always #5 sys_clk = ~sys_clk;

    mdio_responder dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .mdc         (mdc),
        .mdio        (mdio),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always @(negedge sys_clk) begin
        if (reg_wr_en) begin
            wr_cnt++;
            wr_addr_q = reg_addr;
            wr_data_q = reg_wr_data;
        end
        if (reg_rd_en) begin
            rd_cnt++;
            rd_addr_q = reg_addr;
        end
        if (frame_err)
            err_cnt++;
        if (dut.mdio_oe)
            oe_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sta_oe = 1'b1;
        sta_do = b;
        #80 mdc = 1'b1;
        #80 mdc = 1'b0;
    endtask

    task automatic recv_bit(output logic b, output logic oe);
        sta_oe = 1'b0;
        #80;
        b  = mdio;
        oe = dut.mdio_oe;
        mdc = 1'b1;
        #80 mdc = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            send_bit(v[i]);
    endtask

    task automatic header(input int npre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg);
        for (int i = 0; i < npre; i++)
            send_bit(1'b1);
        send_bits(16'(MDIO_ST), 2);
        send_bits(16'(op), 2);
        send_bits(16'(phy), 5);
        send_bits(16'(rg), 5);
    endtask

    task automatic sta_write(input int npre, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] data);
        header(npre, MDIO_OP_WR, phy, rg);
        send_bits(16'b10, 2);
        send_bits(data, 16);
        sta_oe = 1'b0;
        #160;
    endtask

    task automatic sta_read(input logic [4:0] phy, input logic [4:0] rg, output logic [15:0] data,
                            output logic ta1_oe, output logic ta2_bit, output logic ta2_oe);
        logic b, o;
        header(32, MDIO_OP_RD, phy, rg);
        recv_bit(b, ta1_oe);
        recv_bit(ta2_bit, ta2_oe);
        data = '0;
        for (int i = 0; i < 16; i++) begin
            recv_bit(b, o);
            data = {data[14:0], b};
        end
        #160;
    endtask

    initial begin
        int w0, r0, e0, o0;
        logic [15:0] d;
        logic t1o, t2b, t2o, b, o;
        sys_rst_n = 1'b0; mdc = 1'b0; sta_oe = 1'b0; sta_do = 1'b0; reg_rd_data = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wr_data", reg_wr_data, 0);
        check("rst_reg_wr_en", reg_wr_en, 0);
        check("rst_reg_rd_en", reg_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_oe", dut.mdio_oe, 0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        w0 = wr_cnt; o0 = oe_cnt;
        sta_write(32, 5'd0, 5'd0, 16'h0100);
        check("wr1_count", wr_cnt - w0, 1);
        check("wr1_addr", wr_addr_q, 5'd0);
        check("wr1_data", wr_data_q, 16'h0100);
        check("wr1_no_drive", oe_cnt - o0, 0);
        check("wr1_busy_end", busy, 0);

        reg_rd_data = 16'h782D;
        r0 = rd_cnt;
        sta_read(5'd0, 5'd1, d, t1o, t2b, t2o);
        check("rd1_count", rd_cnt - r0, 1);
        check("rd1_addr", rd_addr_q, 5'd1);
        check("rd1_ta1_hiz", t1o, 0);
        check("rd1_ta2_bit", t2b, 0);
        check("rd1_ta2_oe", t2o, 1);
        check("rd1_data", d, 16'h782D);
        check("rd1_hiz_after", dut.mdio_oe, 0);
        check("rd1_busy_end", busy, 0);

        r0 = rd_cnt; o0 = oe_cnt;
        header(32, MDIO_OP_RD, 5'd5, 5'd1);
        check("skip_busy_start", busy, 1);
        for (int i = 0; i < 17; i++)
            recv_bit(b, o);
        check("skip_busy_17", busy, 1);
        recv_bit(b, o);
        check("skip_busy_18", busy, 0);
        check("skip_no_rd", rd_cnt - r0, 0);
        check("skip_no_drive", oe_cnt - o0, 0);

        e0 = err_cnt; w0 = wr_cnt;
        for (int i = 0; i < 32; i++)
            send_bit(1'b1);
        send_bits(16'b00, 2);
        sta_oe = 1'b0;
        #160;
        check("st00_err", err_cnt - e0, 1);
        check("st00_no_wr", wr_cnt - w0, 0);
        check("st00_busy", busy, 0);
        w0 = wr_cnt;
        sta_write(32, 5'd0, 5'd2, 16'hBEEF);
        check("wr2_count", wr_cnt - w0, 1);
        check("wr2_addr", wr_addr_q, 5'd2);
        check("wr2_data", wr_data_q, 16'hBEEF);

        w0 = wr_cnt;
        sta_write(20, 5'd0, 5'd3, 16'h1234);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        check("short_pre_wr", wr_cnt - w0, 1);
        check("short_pre_data", wr_data_q, 16'h1234);
`else
        check("short_pre_wr", wr_cnt - w0, 0);
`endif
        check("short_pre_busy", busy, 0);

        reg_rd_data = 16'h3C3C;
        w0 = wr_cnt;
        header(32, MDIO_OP_RD, 5'd0, 5'd4);
        recv_bit(b, o);
        recv_bit(b, o);
        for (int i = 0; i < 8; i++)
            recv_bit(b, o);
        #40;
        check("mid_rd_oe", dut.mdio_oe, 1);
        sys_rst_n = 1'b0;
        #1;
        check("rst_oe_async", dut.mdio_oe, 0);
        check("rst_busy_async", busy, 0);
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_no_wr", wr_cnt - w0, 0);
        reg_rd_data = 16'hA5A5;
        r0 = rd_cnt;
        sta_read(5'd0, 5'd7, d, t1o, t2b, t2o);
        check("rd2_count", rd_cnt - r0, 1);
        check("rd2_addr", rd_addr_q, 5'd7);
        check("rd2_ta2_bit", t2b, 0);
        check("rd2_data", d, 16'hA5A5);
        check("rd2_hiz_after", dut.mdio_oe, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
